sdram_init_monitor: RTL and testbench
=====================================

// Module: sdram_init_monitor
// PURPOSE
//   Device-side receiver/checker for the SDRAM power-up command stream produced by sdram_init.
//   Samples {cs_n,ras_n,cas_n,we_n}, bank and address each clock. Tracks the JEDEC init sequence
//   (power wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE) and checks command order and spacing.
//   Captures the mode register and flags the first violation. Used in sim benches and as an on-chip monitor.
// PARAMETERS
//   T_POWER   20000  min cycles from reset release to first non-NOP command (200us @100MHz)
//   T_RP      2      min cycles PRECHARGE -> next command
//   T_RFC     7      min cycles AUTO REFRESH -> next command
//   T_MRD     3      cycles LOAD MODE -> init_ok assertion
//   AREF_NUM  8      min AUTO REFRESH count before LOAD MODE (1..15)
// PORTS
//   sys_clk      in   1   100MHz clock, same clock as the command issuer
//   sys_rst_n    in   1   asynchronous active-low reset
//   cmd          in   4   {cs_n,ras_n,cas_n,we_n}
//   ba           in   2   bank address
//   addr         in   13  address bus
//   init_ok      out  1   sequence completed legally; level, sticky until reset
//   init_err     out  1   violation detected; level, sticky until reset
//   err_code     out  3   first violation cause (see below); 0 when no error
//   mode_reg     out  13  addr captured on the legal LOAD MODE
//   aref_cnt     out  4   AUTO REFRESH commands accepted, saturates at 15
// BEHAVIOUR
//   Decode: cs_n=1 DESELECT, 0111 NOP (both "idle"); 0010 PRECHARGE; 0001 AUTO REFRESH; 0000 LOAD MODE;
//     any other non-idle code is "other". All inputs sampled on rising sys_clk, no input registers.
//   Spacing: k = rising edges from previous accepted command to current command; legal iff k >= T_x
//     of previous command (T_RP after PRECHARGE, T_RFC after AUTO REFRESH).
//   Reset: all outputs 0, state S_PWR, power counter 0, gap counter 0.
//   States / transitions (idle cycles never change state except timer expiry):
//     S_PWR  : power counter counts up, saturates at T_POWER. Non-idle command with count < T_POWER
//              -> S_ERR code 1. Non-idle with count = T_POWER: PRECHARGE with addr[10]=1 -> S_PRE,
//              anything else -> S_ERR code 2.
//     S_PRE  : AUTO REFRESH with k>=T_RP -> S_REF, aref_cnt=1. AUTO REFRESH with k<T_RP -> S_ERR code 5.
//              Any other command -> S_ERR code 4.
//     S_REF  : AUTO REFRESH: k<T_RFC -> code 5, else aref_cnt+1 (sat 15).
//              LOAD MODE: k<T_RFC -> code 5; aref_cnt<AREF_NUM -> code 3; ba!=0 -> code 6;
//              else mode_reg<=addr, -> S_MRD. Any other command -> code 4.
//     S_MRD  : count T_MRD cycles; any non-idle command before expiry -> S_ERR code 5;
//              on expiry init_ok<=1, -> S_DONE (init_ok high T_MRD edges after LOAD MODE edge).
//     S_DONE : terminal; later commands ignored, outputs frozen.
//     S_ERR  : terminal; init_err<=1, err_code registered same edge as the offending command;
//              first error only, later commands ignored.
//   Timing checks take priority over order checks when both apply to one command (code 5 wins in
//     S_REF only where listed; in S_PRE/S_REF wrong command type is code 4 regardless of k).
//   init_ok and init_err never both 1. Gap counter saturates (>= max(T_RP,T_RFC,T_MRD)); no wrap.
//   Reset asserted mid-sequence: immediate async return to reset values; power wait restarts.
//   err_code: 1 early cmd, 2 first cmd not PRECHARGE ALL, 3 too few refreshes, 4 illegal command
//     order, 5 spacing violation, 6 LOAD MODE bank != 0.
// TESTING (bench overrides T_POWER=20, T_RP=2, T_RFC=7, T_MRD=3, AREF_NUM=8)
//   Legal stream: PRE(addr=0x400) at 20, 8 AREF every 7, LMR addr=0x032 after 7 -> init_ok=1
//     3 edges after LMR, mode_reg=0x032, aref_cnt=8, init_err=0.
//   PRECHARGE at cycle 10 -> init_err=1, err_code=1 next edge; init_ok stays 0.
//   First command AREF, or PRE with addr[10]=0 -> err_code=2.
//   PRE, 7 legal AREF, LMR -> err_code=3; PRE, AREF, then AREF 6 cycles later -> err_code=5.
//   LMR with ba=2'b01 after 8 AREF -> err_code=6; ACTIVE (0011) in S_REF -> err_code=4.
//   Reset pulse after 4 AREF -> all outputs 0; full legal stream then yields init_ok=1.

Source files
------------

// File: rtl/sdram_init_monitor_if.sv
// Command bus seen by the SDRAM init monitor: {cs_n,ras_n,cas_n,we_n}, bank, address.
interface sdram_init_monitor_if;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;

  modport master (output cmd, ba, addr);
  modport slave  (input  cmd, ba, addr);
endinterface

// File: rtl/sdram_init_monitor.sv
// Checks the SDRAM power-up sequence (power wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE)
// for order and spacing; captures the mode register and latches the first violation.
module sdram_init_monitor #(
  parameter int T_POWER  = 20000,
  parameter int T_RP     = 2,
  parameter int T_RFC    = 7,
  parameter int T_MRD    = 3,
  parameter int AREF_NUM = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  sdram_init_monitor_if.slave  bus,
  output logic                 init_ok,
  output logic                 init_err,
  output logic [2:0]           err_code,
  output logic [12:0]          mode_reg,
  output logic [3:0]           aref_cnt
);

  localparam int GAP_MAX0 = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int GAP_MAX  = (GAP_MAX0 > T_MRD) ? GAP_MAX0 : T_MRD;
  localparam int GW       = $clog2(GAP_MAX + 1);
  localparam int PW       = $clog2(T_POWER + 1);

  localparam logic [GW-1:0] G_RP  = GW'(T_RP);
  localparam logic [GW-1:0] G_RFC = GW'(T_RFC);
  localparam logic [GW-1:0] G_MRD = GW'(T_MRD);
  localparam logic [GW-1:0] G_MAX = GW'(GAP_MAX);
  localparam logic [PW-1:0] P_MAX = PW'(T_POWER);
  localparam logic [3:0]    A_NUM = 4'(AREF_NUM);

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_LMR  = 4'b0000;

  typedef enum logic [2:0] {S_PWR, S_PRE, S_REF, S_MRD, S_DONE, S_ERR} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   pwr_cnt;
  logic [GW-1:0]   gap;
  logic            idle, accept, set_err, set_ok;
  logic [2:0]      err_nx;
  logic [3:0]      aref_nx;
  logic [12:0]     mode_nx;

  assign idle = bus.cmd[3] || (bus.cmd == C_NOP);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    set_err  = 1'b0;
    set_ok   = 1'b0;
    err_nx   = 3'd0;
    aref_nx  = aref_cnt;
    mode_nx  = mode_reg;
    case (state)
      S_PWR: if (!idle) begin
        if (pwr_cnt < P_MAX) begin
          set_err = 1'b1; err_nx = 3'd1;
        end else if (bus.cmd == C_PRE && bus.addr[10]) begin
          state_nx = S_PRE; accept = 1'b1;
        end else begin
          set_err = 1'b1; err_nx = 3'd2;
        end
      end
      S_PRE: if (!idle) begin
        // wrong command type is an order error even when it is also too early
        if (bus.cmd != C_AREF) begin
          set_err = 1'b1; err_nx = 3'd4;
        end else if (gap < G_RP) begin
          set_err = 1'b1; err_nx = 3'd5;
        end else begin
          state_nx = S_REF; accept = 1'b1; aref_nx = 4'd1;
        end
      end
      S_REF: if (!idle) begin
        if (bus.cmd == C_AREF) begin
          if (gap < G_RFC) begin
            set_err = 1'b1; err_nx = 3'd5;
          end else begin
            accept  = 1'b1;
            aref_nx = (aref_cnt == 4'd15) ? aref_cnt : aref_cnt + 4'd1;
          end
        end else if (bus.cmd == C_LMR) begin
          if (gap < G_RFC) begin
            set_err = 1'b1; err_nx = 3'd5;
          end else if (aref_cnt < A_NUM) begin
            set_err = 1'b1; err_nx = 3'd3;
          end else if (bus.ba != 2'd0) begin
            set_err = 1'b1; err_nx = 3'd6;
          end else begin
            state_nx = S_MRD; accept = 1'b1; mode_nx = bus.addr;
          end
        end else begin
          set_err = 1'b1; err_nx = 3'd4;
        end
      end
      S_MRD: begin
        // expiry edge wins over a command landing on that same edge
        if (gap >= G_MRD) begin
          state_nx = S_DONE; set_ok = 1'b1;
        end else if (!idle) begin
          set_err = 1'b1; err_nx = 3'd5;
        end
      end
      default: ;
    endcase
    if (set_err) state_nx = S_ERR;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_PWR;
      pwr_cnt  <= '0;
      gap      <= '0;
      init_ok  <= 1'b0;
      init_err <= 1'b0;
      err_code <= 3'd0;
      mode_reg <= 13'd0;
      aref_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      if (state == S_PWR && pwr_cnt != P_MAX) pwr_cnt <= pwr_cnt + 1'b1;
      // gap = edges since the last accepted command, saturating
      if (accept)            gap <= GW'(1);
      else if (gap != G_MAX) gap <= gap + 1'b1;
      aref_cnt <= aref_nx;
      mode_reg <= mode_nx;
      if (set_ok) init_ok <= 1'b1;
      if (set_err) begin
        init_err <= 1'b1;
        err_code <= err_nx;
      end
    end
  end

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: reset/timing sequences, a vector table of init streams,
// and randomized streams checked against a timestamp-based model of the init rules.
module tb_sdram_init_monitor;
  localparam int T_POWER = 20, T_RP = 2, T_RFC = 7, T_MRD = 3, AREF_NUM = 8;
  localparam logic [3:0] PRE = 4'b0010, AREF = 4'b0001, LMR = 4'b0000, ACT = 4'b0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_ok, init_err;
  logic [2:0]  err_code;
  logic [12:0] mode_reg;
  logic [3:0]  aref_cnt;

  sdram_init_monitor_if bus();

  sdram_init_monitor #(.T_POWER(T_POWER), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
                       .AREF_NUM(AREF_NUM)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus), .init_ok(init_ok), .init_err(init_err),
    .err_code(err_code), .mode_reg(mode_reg), .aref_cnt(aref_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [3:0] cmd; logic [1:0] ba; logic [12:0] addr; int gap; } item_t;
  typedef struct { logic [3:0] cmd; logic [1:0] ba; logic [12:0] addr; int e; } rec_t;
  typedef struct {
    logic [3:0] c0; int e0; logic [12:0] a0; int n_aref; int g1; int gn;
    logic [3:0] cl; int gl; logic [1:0] bl; logic [12:0] al;
    bit x_ok; bit x_err; logic [2:0] x_code; logic [3:0] x_aref; logic [12:0] x_mode;
  } vec_t;

  item_t stim[$];
  rec_t  rec[$];
  int    t;       // rising edges since reset release
  int    last_e;
  int    nvec = 0, nmis = 0;
  vec_t  vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    t++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cmd  = ($urandom % 2) ? 4'b0111 : {1'b1, 3'($urandom)};
      bus.ba   = 2'($urandom);
      bus.addr = 13'($urandom);
      cyc();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd = 4'b1111; bus.ba = 2'd0; bus.addr = 13'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    rec.delete();
  endtask

  task automatic drive_stream();
    foreach (stim[i]) begin
      idle(stim[i].gap - 1);
      bus.cmd = stim[i].cmd; bus.ba = stim[i].ba; bus.addr = stim[i].addr;
      cyc();
      last_e = t;
      rec.push_back('{stim[i].cmd, stim[i].ba, stim[i].addr, t});
    end
    stim.delete();
  endtask

  task automatic push_legal(input logic [12:0] mode);
    stim.push_back('{PRE, 2'd0, 13'h400, T_POWER + 1});
    for (int i = 0; i < AREF_NUM; i++) stim.push_back('{AREF, 2'd0, 13'($urandom), (i == 0) ? T_RP : T_RFC});
    stim.push_back('{LMR, 2'd0, mode, T_RFC});
  endtask

  // Reference: walk the timestamped command list and apply the init rules directly.
  task automatic model(output bit ok, output bit err, output logic [2:0] code,
                       output logic [3:0] n, output logic [12:0] mode);
    int phase, last, lmr_e;
    ok = 0; err = 0; code = 0; n = 0; mode = 0; phase = 0; last = 0; lmr_e = 0;
    foreach (rec[i]) begin
      int k;
      if (ok || err) break;
      k = rec[i].e - last;
      case (phase)
        0: if (rec[i].e - 1 < T_POWER) begin err = 1; code = 1; end
           else if (rec[i].cmd == PRE && rec[i].addr[10]) begin phase = 1; last = rec[i].e; end
           else begin err = 1; code = 2; end
        1: if (rec[i].cmd != AREF) begin err = 1; code = 4; end
           else if (k < T_RP) begin err = 1; code = 5; end
           else begin phase = 2; n = 1; last = rec[i].e; end
        2: if (rec[i].cmd == AREF) begin
             if (k < T_RFC) begin err = 1; code = 5; end
             else begin if (n < 15) n = n + 1; last = rec[i].e; end
           end else if (rec[i].cmd == LMR) begin
             if (k < T_RFC) begin err = 1; code = 5; end
             else if (n < AREF_NUM) begin err = 1; code = 3; end
             else if (rec[i].ba != 0) begin err = 1; code = 6; end
             else begin mode = rec[i].addr; phase = 3; lmr_e = rec[i].e; end
           end else begin err = 1; code = 4; end
        default: if (rec[i].e - lmr_e >= T_MRD) ok = 1;
                 else begin err = 1; code = 5; end
      endcase
    end
    if (phase == 3 && !err && !ok && t - lmr_e >= T_MRD) ok = 1;
  endtask

  task automatic chk_all(input string nm, input bit ok, input bit err, input logic [2:0] code,
                         input logic [3:0] n, input logic [12:0] mode);
    chk({nm, ".init_ok"},  init_ok,  ok);
    chk({nm, ".init_err"}, init_err, err);
    chk({nm, ".err_code"}, err_code, code);
    chk({nm, ".aref_cnt"}, aref_cnt, n);
    chk({nm, ".mode_reg"}, mode_reg, mode);
  endtask

  initial begin
    bit ok, err; logic [2:0] code; logic [3:0] n; logic [12:0] mode;
    //          c0    e0  a0       n   g1 gn cl   gl bl     al        ok err code aref mode
    vt[0]  = '{PRE,  21, 13'h400,  8, 2, 7, LMR, 7, 2'd0, 13'h032,  1, 0, 3'd0, 4'd8,  13'h032};
    vt[1]  = '{PRE,  11, 13'h400,  8, 2, 7, LMR, 7, 2'd0, 13'h032,  0, 1, 3'd1, 4'd0,  13'h000};
    vt[2]  = '{AREF, 21, 13'h400,  8, 2, 7, LMR, 7, 2'd0, 13'h032,  0, 1, 3'd2, 4'd0,  13'h000};
    vt[3]  = '{PRE,  21, 13'h000,  8, 2, 7, LMR, 7, 2'd0, 13'h032,  0, 1, 3'd2, 4'd0,  13'h000};
    vt[4]  = '{PRE,  21, 13'h400,  7, 2, 7, LMR, 7, 2'd0, 13'h032,  0, 1, 3'd3, 4'd7,  13'h000};
    vt[5]  = '{PRE,  21, 13'h400,  2, 2, 6, LMR, 7, 2'd0, 13'h032,  0, 1, 3'd5, 4'd1,  13'h000};
    vt[6]  = '{PRE,  21, 13'h400,  8, 2, 7, LMR, 7, 2'd1, 13'h032,  0, 1, 3'd6, 4'd8,  13'h000};
    vt[7]  = '{PRE,  21, 13'h400,  8, 2, 7, ACT, 7, 2'd0, 13'h032,  0, 1, 3'd4, 4'd8,  13'h000};
    vt[8]  = '{PRE,  21, 13'h400,  8, 1, 7, LMR, 7, 2'd0, 13'h032,  0, 1, 3'd5, 4'd0,  13'h000};
    vt[9]  = '{PRE,  21, 13'h400, 17, 2, 7, LMR, 7, 2'd0, 13'h1AB,  1, 0, 3'd0, 4'd15, 13'h1AB};
    vt[10] = '{PRE,  21, 13'h400,  0, 2, 7, LMR, 5, 2'd0, 13'h032,  0, 1, 3'd4, 4'd0,  13'h000};
    vt[11] = '{PRE,  21, 13'h400,  8, 2, 7, LMR, 6, 2'd0, 13'h032,  0, 1, 3'd5, 4'd8,  13'h000};
    vt[12] = '{PRE,  20, 13'h400,  8, 2, 7, LMR, 7, 2'd0, 13'h032,  0, 1, 3'd1, 4'd0,  13'h000};
    vt[13] = '{PRE,  21, 13'h400,  0, 2, 7, ACT, 1, 2'd0, 13'h032,  0, 1, 3'd4, 4'd0,  13'h000};
    vt[14] = '{PRE,  21, 13'h400,  7, 2, 7, LMR, 6, 2'd0, 13'h032,  0, 1, 3'd5, 4'd7,  13'h000};

    // reset state
    do_reset();
    #1;
    chk_all("reset", 0, 0, 3'd0, 4'd0, 13'd0);

    // legal stream: init_ok rises exactly T_MRD edges after the LOAD MODE edge
    push_legal(13'h032);
    drive_stream();
    chk("lmr_edge.init_ok", init_ok, 1'b0);
    chk("lmr_edge.mode_reg", mode_reg, 13'h032);
    idle(T_MRD - 1);
    chk("mrd_minus1.init_ok", init_ok, 1'b0);
    idle(1);
    chk_all("mrd_expiry", 1, 0, 3'd0, 4'd8, 13'h032);
    stim.push_back('{ACT, 2'd1, 13'h1FFF, 2});
    drive_stream();
    idle(3);
    chk_all("done_frozen", 1, 0, 3'd0, 4'd8, 13'h032);

    // early precharge: error registered on the offending edge
    do_reset();
    idle(10);
    chk("early_pre_before.init_err", init_err, 1'b0);
    stim.push_back('{PRE, 2'd0, 13'h400, 1});
    drive_stream();
    chk("early_pre.init_err", init_err, 1'b1);
    chk("early_pre.err_code", err_code, 3'd1);
    idle(30);
    push_legal(13'h032);
    drive_stream();
    idle(5);
    chk_all("err_sticky", 0, 1, 3'd1, 4'd0, 13'd0);

    // async reset mid-sequence, then a full legal run
    do_reset();
    stim.push_back('{PRE, 2'd0, 13'h400, T_POWER + 1});
    for (int i = 0; i < 4; i++) stim.push_back('{AREF, 2'd0, 13'd0, (i == 0) ? T_RP : T_RFC});
    drive_stream();
    chk("pre_reset.aref_cnt", aref_cnt, 4'd4);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 3'd0, 4'd0, 13'd0);
    do_reset();
    push_legal(13'h0A5);
    drive_stream();
    idle(T_MRD);
    chk_all("after_reset_legal", 1, 0, 3'd0, 4'd8, 13'h0A5);

    // vector table
    foreach (vt[v]) begin
      do_reset();
      stim.push_back('{vt[v].c0, 2'd0, vt[v].a0, vt[v].e0});
      for (int i = 0; i < vt[v].n_aref; i++)
        stim.push_back('{AREF, 2'($urandom), 13'($urandom), (i == 0) ? vt[v].g1 : vt[v].gn});
      stim.push_back('{vt[v].cl, vt[v].bl, vt[v].al, vt[v].gl});
      drive_stream();
      idle(T_MRD + 2);
      chk_all($sformatf("vec%0d", v), vt[v].x_ok, vt[v].x_err, vt[v].x_code, vt[v].x_aref, vt[v].x_mode);
    end

    // randomized streams around the legal sequence
    for (int it = 0; it < 40; it++) begin
      int r, na;
      do_reset();
      r = $urandom % 16;
      stim.push_back('{(r == 0) ? AREF : (r == 1) ? ACT : PRE, 2'($urandom),
                       (($urandom % 8) == 0) ? (13'($urandom) & 13'h1BFF) : (13'($urandom) | 13'h400),
                       18 + int'($urandom % 5)});
      na = 5 + int'($urandom % 12);
      for (int i = 0; i < na; i++) begin
        logic [3:0] c;
        int g;
        c = (($urandom % 16) == 0) ? 4'($urandom % 7) : AREF;
        if (i == 0) g = 1 + int'($urandom % 3);
        else g = (($urandom % 8) == 0) ? T_RFC - 1 : T_RFC + int'($urandom % 3);
        stim.push_back('{c, 2'($urandom), 13'($urandom), g});
      end
      stim.push_back('{LMR, (($urandom % 8) == 0) ? 2'(1 + $urandom % 3) : 2'd0, 13'($urandom),
                       (($urandom % 8) == 0) ? T_RFC - 1 : T_RFC + int'($urandom % 2)});
      if (($urandom % 4) == 0) stim.push_back('{4'($urandom % 7), 2'd0, 13'($urandom), 1 + int'($urandom % 4)});
      drive_stream();
      idle(T_MRD + 2);
      model(ok, err, code, n, mode);
      chk_all($sformatf("rand%0d", it), ok, err, code, n, mode);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
